alarm_zone_sequencer: RTL
=========================

// Module: alarm_zone_sequencer
// PURPOSE
//  Sequencing controller for the security alarm path. Arms and disarms the system
//  with exit and entry delays, and checks a disarm code. Watches NZONES sensor zones
//  (delayed or instant), times the siren and latches which zones tripped. Sits
//  between the raw sensor/keypad inputs and the siren/status outputs; all outputs
//  are registered.
// PARAMETERS
//  NZONES        4      number of sensor zones
//  CW            8      timer width; every *_DLY/SIREN_CYC value must be in 1..2**CW-1
//  EXIT_DLY      16     cycles spent in EXIT after a successful arm
//  ENTRY_DLY     8      cycles spent in ENTRY after a delayed-zone trip
//  SIREN_CYC     32     cycles siren stays on per (re)trigger
//  INSTANT_MASK  4'b0001  zones set here skip ENTRY and go straight to ALARM
//  CODE          4'hA   disarm code
//  MAX_BAD       3      consecutive wrong codes that force ALARM
// PORTS
//  clk           in   1       clock, rising edge
//  rst_n         in   1       reset, asynchronous, active-low
//  arm_req       in   1       1-cycle arm request
//  disarm_req    in   1       1-cycle disarm request; code sampled the same cycle
//  code          in   4       keypad code
//  zone          in   NZONES  sensor levels, 1 = open/tripped (already synchronised)
//  state         out  3       OFF=0 EXIT=1 ARMED=2 ENTRY=3 ALARM=4 HOLD=5
//  siren         out  1       1 only while state==ALARM
//  timer         out  CW      remaining count; 0 in OFF/ARMED/HOLD
//  tripped       out  NZONES  sticky record of zones that caused or joined an event
//  code_err      out  1       1-cycle pulse on wrong-code disarm attempt
//  arm_fail      out  1       1-cycle pulse when arm is refused (a zone is open)
// BEHAVIOUR
//  Reset: state=OFF, siren=0, timer=0, tripped=0, code_err=0, arm_fail=0, bad_cnt=0.
//   Reset mid-sequence aborts immediately, including ALARM.
//  ok = disarm_req & (code==CODE); bad = disarm_req & (code!=CODE).
//  Priority each cycle: ok > bad-limit > instant zone > timer expiry > delayed zone > arm.
//  OFF:   arm_req & zone==0 -> EXIT, timer<=EXIT_DLY-1, tripped<=0, bad_cnt<=0.
//         arm_req & zone!=0 -> stay OFF, arm_fail pulse. disarm_req ignored (no code_err).
//  EXIT:  zones ignored. timer==0 -> ARMED, else timer decrements.
//         State lasts exactly EXIT_DLY cycles.
//  ARMED: zone&INSTANT_MASK !=0 -> ALARM, timer<=SIREN_CYC-1.
//         Other zone!=0 -> ENTRY, timer<=ENTRY_DLY-1. tripped|=zone on that edge.
//  ENTRY: tripped|=zone every cycle. Instant zone -> ALARM.
//         timer==0 -> ALARM, timer<=SIREN_CYC-1.
//  ALARM: siren=1, tripped|=zone. timer==0 -> HOLD.
//  HOLD:  siren=0. Any zone!=0 -> ALARM, timer<=SIREN_CYC-1, tripped|=zone.
//  In EXIT/ARMED/ENTRY/ALARM/HOLD:
//   - ok -> OFF, timer<=0, bad_cnt<=0; tripped is kept for readout.
//   - bad -> code_err pulse, bad_cnt++. Outside ALARM/HOLD, when bad_cnt reaches
//     MAX_BAD -> ALARM, timer<=SIREN_CYC-1; bad_cnt saturates.
//  arm_req is ignored outside OFF. arm_req and ok in the same cycle: ok wins, no arm.
//  All transitions take effect on the clk edge after the inputs are sampled
//   (1-cycle latency). Outputs reflect the new state in that same cycle.
//  timer never underflows; each countdown runs N-1..0 and spans N cycles.
// TESTING
//  Arm with zone=0 -> state=1 for 16 cycles (timer 15..0), then state=2, siren=0.
//  Arm with zone=4'b0100 -> arm_fail high 1 cycle, state stays 0, tripped=0.
//  ARMED, zone[2]=1 for 1 cycle -> ENTRY 8 cycles, then ALARM: siren=1 32 cycles,
//   then HOLD siren=0, tripped=4'b0100.
//  ARMED, zone[0]=1 -> ALARM next cycle (no ENTRY). Disarm code=4'hA in ALARM ->
//   next cycle state=0, siren=0, tripped=4'b0001.
//  ENTRY, three disarms with code=4'h3 -> three code_err pulses, ALARM on the 3rd edge.
//   A following code=4'hA -> OFF.
//  Mid-ALARM, rst_n low 1 cycle (async, between edges) -> all outputs 0 immediately.

Source files
------------

// File: rtl/alarm_zone_sequencer.sv
// ---------------------------------------------------------------------------
// alarm_zone_sequencer
//   Sequencing controller for the alarm path. It arms and disarms the system
//   with exit and entry delays, checks a disarm code, watches NZONES sensor
//   zones (delayed or instant), times the siren and keeps a sticky record of
//   which zones tripped. All outputs are registered.
//
// Ports
//   clk         in   1       clock, rising edge
//   rst_n       in   1       asynchronous active-low reset
//   arm_req     in   1       single-cycle arm request
//   disarm_req  in   1       single-cycle disarm request, code sampled with it
//   code        in   4       keypad code
//   zone        in   NZONES  sensor levels, 1 = open/tripped (synchronised)
//   state       out  3       OFF=0 EXIT=1 ARMED=2 ENTRY=3 ALARM=4 HOLD=5
//   siren       out  1       high only while in ALARM
//   timer       out  CW      remaining count, 0 in OFF/ARMED/HOLD
//   tripped     out  NZONES  sticky record of zones that caused/joined an event
//   code_err    out  1       pulse on a wrong-code disarm attempt
//   arm_fail    out  1       pulse when an arm request is refused
// ---------------------------------------------------------------------------
module alarm_zone_sequencer #(
    parameter int                NZONES       = 4,
    parameter int                CW           = 8,
    parameter int                EXIT_DLY     = 16,
    parameter int                ENTRY_DLY    = 8,
    parameter int                SIREN_CYC    = 32,
    parameter logic [NZONES-1:0] INSTANT_MASK = 4'b0001,
    parameter logic [3:0]        CODE         = 4'hA,
    parameter int                MAX_BAD      = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm_req,
    input  logic              disarm_req,
    input  logic [3:0]        code,
    input  logic [NZONES-1:0] zone,
    output logic [2:0]        state,
    output logic              siren,
    output logic [CW-1:0]     timer,
    output logic [NZONES-1:0] tripped,
    output logic              code_err,
    output logic              arm_fail
);

    localparam int BW = $clog2(MAX_BAD + 1);

    // Countdowns load N-1 so that each one spans exactly N cycles.
    localparam logic [CW-1:0] EXIT_LD  = CW'(EXIT_DLY - 1);
    localparam logic [CW-1:0] ENTRY_LD = CW'(ENTRY_DLY - 1);
    localparam logic [CW-1:0] SIREN_LD = CW'(SIREN_CYC - 1);
    localparam logic [BW-1:0] BAD_MAX  = BW'(MAX_BAD);

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_EXIT  = 3'd1,
        S_ARMED = 3'd2,
        S_ENTRY = 3'd3,
        S_ALARM = 3'd4,
        S_HOLD  = 3'd5
    } state_t;

    state_t        st;
    logic [BW-1:0] bad_cnt;

    // Wrong-code counter stops at MAX_BAD so repeated bad codes keep the limit.
    function automatic logic [BW-1:0] sat_inc(input logic [BW-1:0] v);
        return (v >= BAD_MAX) ? BAD_MAX : v + 1'b1;
    endfunction

    logic          ok;
    logic          bad;
    logic [BW-1:0] bad_next;
    logic          bad_limit;
    logic          instant_hit;
    logic          any_zone;

    assign ok          = disarm_req && (code == CODE);
    assign bad         = disarm_req && (code != CODE);
    assign bad_next    = sat_inc(bad_cnt);
    assign bad_limit   = bad && (bad_next == BAD_MAX);
    assign instant_hit = (zone & INSTANT_MASK) != '0;
    assign any_zone    = zone != '0;

    assign state = st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= S_OFF;
            siren    <= 1'b0;
            timer    <= '0;
            tripped  <= '0;
            code_err <= 1'b0;
            arm_fail <= 1'b0;
            bad_cnt  <= '0;
        end else begin
            code_err <= 1'b0;
            arm_fail <= 1'b0;
            siren    <= 1'b0;
            if (st == S_OFF) begin
                // A valid code presented alongside an arm request cancels it.
                if (arm_req && !ok) begin
                    if (!any_zone) begin
                        st      <= S_EXIT;
                        timer   <= EXIT_LD;
                        tripped <= '0;
                        bad_cnt <= '0;
                    end else begin
                        arm_fail <= 1'b1;
                    end
                end
            end else if (ok) begin
                // tripped is left untouched so the event can be read out.
                st      <= S_OFF;
                timer   <= '0;
                bad_cnt <= '0;
            end else begin
                if (bad) begin
                    code_err <= 1'b1;
                    bad_cnt  <= bad_next;
                end
                if (bad_limit && st != S_ALARM && st != S_HOLD) begin
                    st    <= S_ALARM;
                    timer <= SIREN_LD;
                    siren <= 1'b1;
                    if (st == S_ENTRY)
                        tripped <= tripped | zone;
                end else begin
                    case (st)
                        S_EXIT: begin
                            if (timer == '0)
                                st <= S_ARMED;
                            else
                                timer <= timer - 1'b1;
                        end
                        S_ARMED: begin
                            tripped <= tripped | zone;
                            if (instant_hit) begin
                                st    <= S_ALARM;
                                timer <= SIREN_LD;
                                siren <= 1'b1;
                            end else if (any_zone) begin
                                st    <= S_ENTRY;
                                timer <= ENTRY_LD;
                            end
                        end
                        S_ENTRY: begin
                            tripped <= tripped | zone;
                            if (instant_hit || timer == '0) begin
                                st    <= S_ALARM;
                                timer <= SIREN_LD;
                                siren <= 1'b1;
                            end else begin
                                timer <= timer - 1'b1;
                            end
                        end
                        S_ALARM: begin
                            tripped <= tripped | zone;
                            if (timer == '0) begin
                                st <= S_HOLD;
                            end else begin
                                timer <= timer - 1'b1;
                                siren <= 1'b1;
                            end
                        end
                        S_HOLD: begin
                            if (any_zone) begin
                                st      <= S_ALARM;
                                timer   <= SIREN_LD;
                                siren   <= 1'b1;
                                tripped <= tripped | zone;
                            end
                        end
                        default: begin
                            st    <= S_OFF;
                            timer <= '0;
                        end
                    endcase
                end
            end
        end
    end

endmodule
